// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter:
// mem_op codes, FSM states and owner ids.
package mem_bus_arbiter_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] LB      = 4'd1;
  localparam logic [3:0] LH      = 4'd2;
  localparam logic [3:0] LW      = 4'd3;
  localparam logic [3:0] LBU     = 4'd4;
  localparam logic [3:0] LHU     = 4'd5;
  localparam logic [3:0] SB      = 4'd6;
  localparam logic [3:0] SH      = 4'd7;
  localparam logic [3:0] SW      = 4'd8;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUS_ADDR = 2'd1;
  localparam logic [1:0] BUS_WAIT = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch, data and memory-bus signals of the arbiter.
// slave = arbiter view, master = requesters/bus-slave view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic [DATA_WIDTH-1:0] if_rdata_o;
  logic                  if_ack_o;
  logic                  d_req_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic [3:0]            d_op_i;
  logic [DATA_WIDTH-1:0] d_rdata_o;
  logic                  d_ack_o;
  logic                  d_misalign_o;
  logic                  bus_err_o;
  logic                  stallreq_o;
  logic                  bus_req_o;
  logic [ADDR_WIDTH-1:0] bus_addr_o;
  logic                  bus_we_o;
  logic [3:0]            bus_be_o;
  logic [DATA_WIDTH-1:0] bus_wdata_o;
  logic                  bus_gnt_i;
  logic                  bus_rvalid_i;
  logic [DATA_WIDTH-1:0] bus_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_addr_i, d_wdata_i, d_op_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    output if_rdata_o, if_ack_o,
    output d_rdata_o, d_ack_o, d_misalign_o,
    output bus_err_o, stallreq_o,
    output bus_req_o, bus_addr_o, bus_we_o,
    output bus_be_o, bus_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_addr_i, d_wdata_i, d_op_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    input  if_rdata_o, if_ack_o,
    input  d_rdata_o, d_ack_o, d_misalign_o,
    input  bus_err_o, stallreq_o,
    input  bus_req_o, bus_addr_o, bus_we_o,
    input  bus_be_o, bus_wdata_o
  );
endinterface

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store enables/replication,
// misalignment check and load extraction.
module mem_lane_fmt
  import mem_bus_arbiter_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        we_o,
  output logic        misalign_o,
  output logic        valid_o,
  output logic [31:0] rdata_o
);
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata_i[{lane_i, 3'b000} +: 8];
  assign half_s = lane_i[1] ? rdata_i[31:16]
                            : rdata_i[15:0];

  always_comb begin
    be_o       = 4'h0;
    wdata_o    = '0;
    we_o       = 1'b0;
    misalign_o = 1'b0;
    valid_o    = 1'b1;
    rdata_o    = '0;
    unique case (1'b1)
      (op_i == LB): begin
        be_o    = 4'hF;
        rdata_o = {{24{byte_s[7]}}, byte_s};
      end
      (op_i == LBU): begin
        be_o    = 4'hF;
        rdata_o = {24'h0, byte_s};
      end
      (op_i == LH): begin
        be_o       = 4'hF;
        misalign_o = lane_i[0];
        rdata_o    = {{16{half_s[15]}}, half_s};
      end
      (op_i == LHU): begin
        be_o       = 4'hF;
        misalign_o = lane_i[0];
        rdata_o    = {16'h0, half_s};
      end
      (op_i == LW): begin
        be_o       = 4'hF;
        misalign_o = |lane_i;
        rdata_o    = rdata_i;
      end
      (op_i == SB): begin
        we_o    = 1'b1;
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      (op_i == SH): begin
        we_o       = 1'b1;
        be_o       = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = lane_i[0];
      end
      (op_i == SW): begin
        we_o       = 1'b1;
        be_o       = 4'hF;
        wdata_o    = wdata_i;
        misalign_o = |lane_i;
      end
      (op_i == MEM_NOP): valid_o = 1'b0;
      default:           valid_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and data masters onto one memory bus,
// one transfer at a time, with streak fairness and timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_STREAK_MAX = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input logic            clk_i,
  input logic            rst_i,
  mem_bus_arbiter_if.slave b
);
  localparam int SW = $clog2(DATA_STREAK_MAX + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            op_q, op_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  mis_q, mis_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic        idle, resp, d_win, tmo;
  logic [3:0]  f_op, f_be;
  logic [1:0]  f_lane;
  logic [31:0] f_wdata, f_rdata;
  logic        f_we, f_mis, f_ok;

  assign idle  = (state_q == IDLE);
  assign resp  = (state_q == RESP);
  assign tmo   = (cnt_q == TMO_LAST);
  assign d_win = b.d_req_i &&
                 !(b.if_req_i && streak_q == STREAK_MAX);

  // Live request in IDLE, latched op/lane once in flight
  assign f_op   = idle ? b.d_op_i : op_q;
  assign f_lane = idle ? b.d_addr_i[1:0] : addr_q[1:0];

  mem_lane_fmt u_fmt (
    .op_i      (f_op),
    .lane_i    (f_lane),
    .wdata_i   (b.d_wdata_i),
    .rdata_i   (b.bus_rdata_i),
    .be_o      (f_be),
    .wdata_o   (f_wdata),
    .we_o      (f_we),
    .misalign_o(f_mis),
    .valid_o   (f_ok),
    .rdata_o   (f_rdata)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    op_d     = op_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mis_d    = mis_q;
    streak_d = streak_q;
    cnt_d    = cnt_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        cnt_d   = '0;
        err_d   = 1'b0;
        rdata_d = '0;
        if (d_win) begin
          owner_d  = OWNER_D;
          streak_d = (streak_q == STREAK_MAX)
                     ? streak_q : streak_q + SW'(1);
          addr_d   = b.d_addr_i;
          op_d     = b.d_op_i;
          we_d     = f_we;
          be_d     = f_be;
          wdata_d  = f_wdata;
          mis_d    = f_ok && f_mis;
          state_d  = (f_ok && !f_mis) ? BUS_ADDR : RESP;
        end else if (b.if_req_i) begin
          owner_d  = OWNER_IF;
          streak_d = '0;
          addr_d   = b.if_addr_i;
          op_d     = LW;
          we_d     = 1'b0;
          be_d     = 4'hF;
          wdata_d  = '0;
          mis_d    = 1'b0;
          state_d  = BUS_ADDR;
        end
      end
      (state_q == BUS_ADDR): begin
        cnt_d = cnt_q + CW'(1);
        if (b.bus_gnt_i && b.bus_rvalid_i) begin
          rdata_d = f_rdata;
          state_d = RESP;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (b.bus_gnt_i) begin
          state_d = BUS_WAIT;
        end
      end
      (state_q == BUS_WAIT): begin
        cnt_d = cnt_q + CW'(1);
        if (b.bus_rvalid_i) begin
          rdata_d = f_rdata;
          state_d = RESP;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      owner_q  <= OWNER_IF;
      addr_q   <= '0;
      op_q     <= MEM_NOP;
      we_q     <= 1'b0;
      be_q     <= 4'h0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
      streak_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      op_q     <= op_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      mis_q    <= mis_d;
      streak_q <= streak_d;
      cnt_q    <= cnt_d;
    end
  end

  assign b.if_ack_o     = resp && (owner_q == OWNER_IF);
  assign b.d_ack_o      = resp && (owner_q == OWNER_D);
  assign b.if_rdata_o   = b.if_ack_o ? rdata_q : '0;
  assign b.d_rdata_o    = b.d_ack_o ? rdata_q : '0;
  assign b.d_misalign_o = b.d_ack_o && mis_q;
  assign b.bus_err_o    = resp && err_q;
  assign b.stallreq_o   = b.d_req_i && !b.d_ack_o;
  assign b.bus_req_o    = (state_q == BUS_ADDR);
  assign b.bus_addr_o   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign b.bus_we_o     = we_q;
  assign b.bus_be_o     = be_q;
  assign b.bus_wdata_o  = wdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
// Small TIMEOUT_CYCLES keeps the timeout scenario short.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic        slv_on = 1'b0;
  logic        slv_gnt = 1'b0;
  logic        stale = 1'b0;
  logic [31:0] slv_data = '0;

  int          o_lat, o_breq;
  logic [31:0] o_rd, o_wd, o_ad;
  logic [3:0]  o_be;
  logic        o_we, o_mis, o_err;
  logic        o_stall_bad, o_stall_ack, o_breq_ack;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

  assign bif.bus_gnt_i    = bif.bus_req_o & (slv_on | slv_gnt);
  assign bif.bus_rvalid_i = (bif.bus_req_o & slv_on) | stale;
  assign bif.bus_rdata_i  = slv_data;

  mem_bus_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .DATA_STREAK_MAX(4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .b    (bif)
  );

  task automatic clear_inputs();
    bif.if_req_i  = 1'b0;
    bif.if_addr_i = '0;
    bif.d_req_i   = 1'b0;
    bif.d_addr_i  = '0;
    bif.d_wdata_i = '0;
    bif.d_op_i    = MEM_NOP;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_i = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
  endtask

  // Drives one data request and records what the bus and ack showed
  task automatic run_d(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    @(posedge clk); #1;
    bif.d_req_i   = 1'b1;
    bif.d_op_i    = op;
    bif.d_addr_i  = a;
    bif.d_wdata_i = wd;
    o_lat = -1; o_breq = 0; o_stall_bad = 1'b0;
    o_be = '0; o_wd = '0; o_ad = '0; o_we = 1'b0;
    o_rd = '0; o_mis = 1'b0; o_err = 1'b0;
    o_stall_ack = 1'b0; o_breq_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bif.bus_req_o) begin
        if (o_breq == 0) begin
          o_be = bif.bus_be_o;
          o_wd = bif.bus_wdata_o;
          o_ad = bif.bus_addr_o;
          o_we = bif.bus_we_o;
        end
        o_breq++;
      end
      if (bif.d_ack_o) begin
        o_lat       = c;
        o_rd        = bif.d_rdata_o;
        o_mis       = bif.d_misalign_o;
        o_err       = bif.bus_err_o;
        o_stall_ack = bif.stallreq_o;
        o_breq_ack  = bif.bus_req_o;
        break;
      end
      if (!bif.stallreq_o) o_stall_bad = 1'b1;
    end
    bif.d_req_i = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_i = 1'b0;
    clear_inputs();
    bif.d_req_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bif.bus_req_o, bif.if_ack_o, bif.d_ack_o,
         bif.bus_err_o, bif.d_misalign_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bif.bus_req_o, bif.if_ack_o, bif.d_ack_o,
                bif.bus_err_o, bif.d_misalign_o});
    end
    n_chk++;
    if (bif.bus_be_o !== 4'h0 || bif.bus_addr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: be=%h addr=%h want 0",
               bif.bus_be_o, bif.bus_addr_o);
    end
    n_chk++;
    if (bif.stallreq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall_hi: got %b want 1",
               bif.stallreq_o);
    end
    bif.d_req_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bif.stallreq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall_lo: got %b want 0",
               bif.stallreq_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b1;
  endtask

  task automatic test_fetch();
    slv_on = 1'b1;
    slv_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    bif.if_req_i  = 1'b1;
    bif.if_addr_i = 32'h100;
    @(negedge clk);
    n_chk++;
    if (bif.bus_req_o !== 1'b0 || bif.if_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_n: req=%b ack=%b want 0 0",
               bif.bus_req_o, bif.if_ack_o);
    end
    @(negedge clk);
    n_chk++;
    if ({bif.bus_req_o, bif.bus_we_o, bif.bus_be_o,
         bif.bus_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      n_fail++;
      $display("FAIL fetch_bus: req=%b we=%b be=%h a=%h",
               bif.bus_req_o, bif.bus_we_o, bif.bus_be_o,
               bif.bus_addr_o);
    end
    @(negedge clk);
    n_chk++;
    if (bif.if_ack_o !== 1'b1 ||
        bif.if_rdata_o !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL fetch_ack: ack=%b data=%h want 1 deadbeef",
               bif.if_ack_o, bif.if_rdata_o);
    end
    bif.if_req_i = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bif.if_ack_o !== 1'b0 || bif.bus_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_one_pulse: ack=%b req=%b want 0 0",
               bif.if_ack_o, bif.bus_req_o);
    end
  endtask

  task automatic test_loads();
    logic [3:0]  ops [6];
    logic [31:0] adr [6];
    logic [31:0] exp [6];
    ops = '{LB, LBU, LHU, LH, LB, LW};
    adr = '{32'h203, 32'h203, 32'h202, 32'h202,
            32'h201, 32'h200};
    exp = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF,
            32'hFFFF80FF, 32'h0000007F, 32'h80FF7F01};
    slv_on = 1'b1;
    slv_data = 32'h80FF7F01;
    for (int i = 0; i < 6; i++) begin
      run_d(ops[i], adr[i], 32'h0);
      n_chk++;
      if (o_lat !== 2 || o_rd !== exp[i] || o_mis !== 1'b0) begin
        n_fail++;
        $display("FAIL load_%0d: lat=%0d data=%h mis=%b want 2 %h 0",
                 i, o_lat, o_rd, o_mis, exp[i]);
      end
    end
  endtask

  task automatic test_stores();
    logic [3:0]  ops [3];
    logic [31:0] adr [3];
    logic [31:0] wdi [3];
    logic [3:0]  ebe [3];
    logic [31:0] ewd [3];
    logic [31:0] ead [3];
    ops = '{SH, SB, SW};
    adr = '{32'h206, 32'h105, 32'h108};
    wdi = '{32'h1234ABCD, 32'h0000005A, 32'hCAFEF00D};
    ebe = '{4'b1100, 4'b0010, 4'b1111};
    ewd = '{32'hABCDABCD, 32'h5A5A5A5A, 32'hCAFEF00D};
    ead = '{32'h204, 32'h104, 32'h108};
    slv_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_d(ops[i], adr[i], wdi[i]);
      n_chk++;
      if (o_be !== ebe[i] || o_wd !== ewd[i] ||
          o_ad !== ead[i] || o_we !== 1'b1) begin
        n_fail++;
        $display("FAIL store_%0d: be=%b wd=%h a=%h we=%b want %b %h %h 1",
                 i, o_be, o_wd, o_ad, o_we, ebe[i], ewd[i], ead[i]);
      end
      n_chk++;
      if (o_lat !== 2 || o_stall_bad !== 1'b0 ||
          o_stall_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL store_stall_%0d: lat=%0d gap=%b at_ack=%b want 2 0 0",
                 i, o_lat, o_stall_bad, o_stall_ack);
      end
    end
  endtask

  task automatic test_no_bus();
    logic [3:0]  ops [5];
    logic [31:0] adr [5];
    logic        emis [5];
    ops  = '{LW, SH, LH, MEM_NOP, 4'hF};
    adr  = '{32'h101, 32'h203, 32'h201, 32'h200, 32'h200};
    emis = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    slv_on = 1'b1;
    slv_data = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      run_d(ops[i], adr[i], 32'hFFFFFFFF);
      n_chk++;
      if (o_lat !== 1 || o_breq !== 0 || o_rd !== 32'h0 ||
          o_mis !== emis[i] || o_err !== 1'b0) begin
        n_fail++;
        $display("FAIL nobus_%0d: lat=%0d breq=%0d rd=%h mis=%b err=%b want 1 0 0 %b 0",
                 i, o_lat, o_breq, o_rd, o_mis, o_err, emis[i]);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [9:0] exp_ord;
    logic [9:0] got;
    int n;
    exp_ord = 10'b0111101111;
    got = '0;
    n = 0;
    apply_reset();
    slv_on = 1'b1;
    slv_data = 32'h11223344;
    @(posedge clk); #1;
    bif.if_req_i  = 1'b1;
    bif.if_addr_i = 32'h80;
    bif.d_req_i   = 1'b1;
    bif.d_op_i    = LW;
    bif.d_addr_i  = 32'h300;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge clk);
      if (bif.d_ack_o) begin got[n] = 1'b1; n++; end
      else if (bif.if_ack_o) begin got[n] = 1'b0; n++; end
    end
    bif.if_req_i = 1'b0;
    bif.d_req_i  = 1'b0;
    n_chk++;
    if (n !== 10) begin
      n_fail++;
      $display("FAIL arb_count: got %0d grants want 10", n);
    end
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (got[i] !== exp_ord[i]) begin
        n_fail++;
        $display("FAIL arb_order_%0d: got %s want %s", i,
                 got[i] ? "D" : "IF", exp_ord[i] ? "D" : "IF");
      end
    end
  endtask

  task automatic test_timeout();
    slv_on = 1'b0;
    run_d(LW, 32'h400, 32'h0);
    n_chk++;
    if (o_breq !== 8 || o_lat !== 9 || o_breq_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_len: breq=%0d lat=%0d req_at_ack=%b want 8 9 0",
               o_breq, o_lat, o_breq_ack);
    end
    n_chk++;
    if (o_err !== 1'b1 || o_rd !== 32'h0 || o_mis !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_resp: err=%b rd=%h mis=%b want 1 0 0",
               o_err, o_rd, o_mis);
    end
    @(negedge clk);
    n_chk++;
    if (bif.bus_err_o !== 1'b0 || bif.d_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_pulse: err=%b ack=%b want 0 0",
               bif.bus_err_o, bif.d_ack_o);
    end
  endtask

  task automatic test_reset_in_wait();
    slv_on  = 1'b0;
    slv_gnt = 1'b1;
    @(posedge clk); #1;
    bif.d_req_i  = 1'b1;
    bif.d_op_i   = LW;
    bif.d_addr_i = 32'h500;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (bif.bus_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_addr: req=%b want 1", bif.bus_req_o);
    end
    @(negedge clk);
    n_chk++;
    if (bif.bus_req_o !== 1'b0 || bif.d_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_wait: req=%b ack=%b want 0 0",
               bif.bus_req_o, bif.d_ack_o);
    end
    rst_i = 1'b0;
    bif.d_req_i = 1'b0;
    slv_gnt = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    stale = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) stale = 1'b0;
      n_chk++;
      if ({bif.d_ack_o, bif.if_ack_o, bif.bus_req_o,
           bif.bus_err_o} !== 4'b0) begin
        n_fail++;
        $display("FAIL rw_stale_%0d: dack=%b iack=%b req=%b err=%b want 0",
                 c, bif.d_ack_o, bif.if_ack_o, bif.bus_req_o,
                 bif.bus_err_o);
      end
    end
    stale = 1'b0;
  endtask

  task automatic test_back_to_back();
    slv_on = 1'b1;
    slv_data = 32'h0BADF00D;
    run_d(LW, 32'h600, 32'h0);
    n_chk++;
    if (o_lat !== 2 || o_rd !== 32'h0BADF00D || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_0: lat=%0d rd=%h err=%b want 2 0badf00d 0",
               o_lat, o_rd, o_err);
    end
    slv_data = 32'h00008001;
    run_d(LH, 32'h600, 32'h0);
    n_chk++;
    if (o_lat !== 2 || o_rd !== 32'hFFFF8001) begin
      n_fail++;
      $display("FAIL b2b_1: lat=%0d rd=%h want 2 ffff8001",
               o_lat, o_rd);
    end
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    test_fetch();
    test_loads();
    test_stores();
    test_no_bus();
    test_arbitration();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
